// File: rtl/clint_pkg.sv
// Shared definitions for the memory-mapped machine timer: access modes,
// register offsets, control bit positions and reset constants.
package clint_pkg;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mem_acc_mode_e;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PRESCALE    = 5'h14;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam logic [63:0] MTIMECMP_RST = '1;

endpackage

// File: rtl/clint_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale + 1) enabled cycles.
module clint_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: bus decode, byte-lane merge/extend,
// 64-bit mtime/mtimecmp registers and the registered compare interrupt.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        err,
    output logic        timer_interrupt
);

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               ctrl_en;
    logic               ctrl_irq_en;
    logic [PRESC_W-1:0] prescale;
    logic               tick;

    mem_acc_mode_e mode;
    logic          legal, size_b, size_h, size_w, misalign;
    logic          acc_ok, do_wr, do_rd;
    logic [2:0]    wsel;
    logic [3:0]    lane_mask;
    logic [31:0]   bit_mask, wlanes, cur_word, merged, rd_shift;
    logic          sext;

    assign mode = mem_acc_mode_e'(mem_acc_mode);
    assign wsel = addr[4:2];
    assign sext = ~mem_acc_mode[2];

    always_comb begin
        size_b = 1'b0;
        size_h = 1'b0;
        size_w = 1'b0;
        legal  = 1'b1;
        case (mode)
            MODE_B, MODE_BU: size_b = 1'b1;
            MODE_H, MODE_HU: size_h = 1'b1;
            MODE_W:          size_w = 1'b1;
            default:         legal  = 1'b0;
        endcase
    end

    assign misalign = (size_h & addr[0]) | (size_w & (|addr[1:0]));
    assign hit      = (addr[31:5] == BASE_ADDR[31:5]) && (rd_en || wr_en);
    assign err      = hit & (~legal | misalign);
    assign acc_ok   = hit & ~err;
    assign do_wr    = acc_ok & wr_en;
    assign do_rd    = acc_ok & rd_en & ~wr_en;

    always_comb begin
        case (wsel)
            OFF_MTIME_LO[4:2]:    cur_word = mtime[31:0];
            OFF_MTIME_HI[4:2]:    cur_word = mtime[63:32];
            OFF_MTIMECMP_LO[4:2]: cur_word = mtimecmp[31:0];
            OFF_MTIMECMP_HI[4:2]: cur_word = mtimecmp[63:32];
            OFF_CTRL[4:2]: begin
                cur_word                  = '0;
                cur_word[CTRL_EN_BIT]     = ctrl_en;
                cur_word[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
            end
            OFF_PRESCALE[4:2]:    cur_word = 32'(prescale);
            default:              cur_word = '0;
        endcase
    end

    // Sub-word stores replicate the source lanes across the word and let the
    // byte mask pick the addressed lane(s), so one merge serves all sizes.
    always_comb begin
        if (size_w) begin
            lane_mask = 4'b1111;
            wlanes    = wdata;
        end else if (size_h) begin
            lane_mask = 4'b0011 << addr[1:0];
            wlanes    = {2{wdata[15:0]}};
        end else begin
            lane_mask = 4'b0001 << addr[1:0];
            wlanes    = {4{wdata[7:0]}};
        end
        for (int unsigned i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
    end

    assign merged   = (cur_word & ~bit_mask) | (wlanes & bit_mask);
    assign rd_shift = cur_word >> {addr[1:0], 3'b000};

    always_comb begin
        rdata = '0;
        if (do_rd) begin
            if (size_w)      rdata = rd_shift;
            else if (size_h) rdata = {{16{sext & rd_shift[15]}}, rd_shift[15:0]};
            else             rdata = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
        end
    end

    clint_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_en),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime           <= '0;
            mtimecmp        <= MTIMECMP_RST;
            ctrl_en         <= 1'b0;
            ctrl_irq_en     <= 1'b0;
            prescale        <= '0;
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= ctrl_irq_en && (mtime >= mtimecmp);
            // A software write to either mtime half overrides that cycle's tick.
            if (do_wr && wsel == OFF_MTIME_LO[4:2])      mtime[31:0]  <= merged;
            else if (do_wr && wsel == OFF_MTIME_HI[4:2]) mtime[63:32] <= merged;
            else if (tick)                               mtime        <= mtime + 64'd1;
            if (do_wr && wsel == OFF_MTIMECMP_LO[4:2]) mtimecmp[31:0]  <= merged;
            if (do_wr && wsel == OFF_MTIMECMP_HI[4:2]) mtimecmp[63:32] <= merged;
            if (do_wr && wsel == OFF_CTRL[4:2]) begin
                ctrl_en     <= merged[CTRL_EN_BIT];
                ctrl_irq_en <= merged[CTRL_IRQ_EN_BIT];
            end
            if (do_wr && wsel == OFF_PRESCALE[4:2]) prescale <= merged[PRESC_W-1:0];
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus random bus
// traffic, all checked against a byte-addressed behavioural model.
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  mem_acc_mode = 3'b010;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit, err, timer_interrupt;

    int vectors = 0;
    int miscompares = 0;

    clint_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .mem_acc_mode    (mem_acc_mode),
        .wdata           (wdata),
        .rdata           (rdata),
        .hit             (hit),
        .err             (err),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    // Model state: the register window is treated as a small byte memory.
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_ie, m_irq;
    logic [15:0] m_presc, m_pcnt;

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = {64{1'b1}};
        m_en    = 1'b0;
        m_ie    = 1'b0;
        m_presc = 16'd0;
        m_pcnt  = 16'd0;
        m_irq   = 1'b0;
    endtask

    function automatic logic [7:0] m_byte(input logic [4:0] b);
        logic [7:0] v;
        v = 8'h00;
        if (b < 5'd8)        v = 8'(m_mtime >> (8 * int'(b)));
        else if (b < 5'd16)  v = 8'(m_cmp >> (8 * (int'(b) - 8)));
        else if (b == 5'd16) v = {6'b0, m_ie, m_en};
        else if (b == 5'd20) v = m_presc[7:0];
        else if (b == 5'd21) v = m_presc[15:8];
        return v;
    endfunction

    task automatic expect_comb(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [2:0] md, output logic e_hit,
                               output logic e_err, output logic [31:0] e_rd);
        int   sz;
        logic legal;
        logic [4:0] b;
        e_hit = (a[31:5] == BASE[31:5]) && (rd || wr);
        legal = (md == 3'd0) || (md == 3'd1) || (md == 3'd2) || (md == 3'd4) || (md == 3'd5);
        sz    = 1 << md[1:0];
        e_err = e_hit && (!legal || (int'(a[1:0]) % sz) != 0);
        e_rd  = 32'd0;
        if (e_hit && !e_err && rd && !wr) begin
            for (int i = 0; i < sz; i++) begin
                b = 5'(int'(a[4:0]) + i);
                e_rd[8*i +: 8] = m_byte(b);
            end
            if (!md[2] && sz < 4 && e_rd[8*sz-1])
                for (int i = sz; i < 4; i++) e_rd[8*i +: 8] = 8'hFF;
        end
    endtask

    // One clock edge of the model, using the pre-edge state for tick and compare.
    task automatic model_step(input logic do_wr, input logic [31:0] a,
                              input logic [2:0] md, input logic [31:0] wd);
        logic tick, en_pre, irq_n, mt_written;
        logic [4:0] b;
        logic [7:0] v;
        en_pre     = m_en;
        tick       = m_en && (m_pcnt == m_presc);
        irq_n      = m_ie && (m_mtime >= m_cmp);
        mt_written = 1'b0;
        if (do_wr) begin
            for (int i = 0; i < (1 << md[1:0]); i++) begin
                b = 5'(int'(a[4:0]) + i);
                v = wd[8*i +: 8];
                if (b < 5'd8) begin
                    m_mtime[8*int'(b) +: 8] = v;
                    mt_written = 1'b1;
                end else if (b < 5'd16) begin
                    m_cmp[8*(int'(b)-8) +: 8] = v;
                end else if (b == 5'd16) begin
                    m_en = v[0];
                    m_ie = v[1];
                end else if (b == 5'd20) m_presc[7:0]  = v;
                else if (b == 5'd21)     m_presc[15:8] = v;
            end
        end
        if (!mt_written && tick) m_mtime = m_mtime + 64'd1;
        if (en_pre) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        m_irq = irq_n;
    endtask

    // Drives one bus cycle from a negedge; returns observed and modelled outputs.
    task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] md, input logic [31:0] wd,
                       output logic [31:0] o_rd, output logic o_hit, output logic o_err,
                       output logic [31:0] e_rd, output logic e_hit, output logic e_err);
        rd_en = rd; wr_en = wr; addr = a; mem_acc_mode = md; wdata = wd;
        #1;
        o_rd = rdata; o_hit = hit; o_err = err;
        expect_comb(rd, wr, a, md, e_hit, e_err, e_rd);
        @(posedge clk);
        model_step(e_hit && !e_err && wr, a, md, wd);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic store(input logic [4:0] off, input logic [2:0] md, input logic [31:0] wd);
        logic [31:0] o, e; logic oh, eh, oe, ee;
        bus(1'b0, 1'b1, BASE | 32'(off), md, wd, o, oh, oe, e, eh, ee);
    endtask

    task automatic idle(input int n);
        logic [31:0] o, e; logic oh, eh, oe, ee;
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] o, e, want[8]; logic oh, eh, oe, ee;
        want = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        vectors++;
        if (timer_interrupt !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b exp 0", timer_interrupt);
        end
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, 1'b0, BASE + 32'(4 * i), 3'd2, 32'd0, o, oh, oe, e, eh, ee);
            vectors++;
            if (o !== want[i] || oh !== 1'b1 || oe !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read off=%0h: got %h hit=%b err=%b exp %h hit=1 err=0", 4 * i, o, oh, oe, want[i]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] o, e; logic oh, eh, oe, ee;
        do_reset();
        store(5'h14, 3'd2, 32'd3);
        store(5'h10, 3'd2, 32'd1);
        idle(20);
        bus(1'b1, 1'b0, BASE, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'd5 || o !== e) begin
            miscompares++; $display("FAIL prescale_mtime: got %0d exp 5 (model %0d)", o, e);
        end
    endtask

    task automatic test_irq();
        int rise_seen = 0;
        logic [31:0] o, e; logic oh, eh, oe, ee;
        do_reset();
        store(5'h08, 3'd2, 32'd10);
        store(5'h0C, 3'd2, 32'd0);
        store(5'h14, 3'd2, 32'd0);
        store(5'h10, 3'd2, 32'd3);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            vectors++;
            if (timer_interrupt !== m_irq) begin
                miscompares++; $display("FAIL irq_rise cyc=%0d: got %b exp %b", i, timer_interrupt, m_irq);
            end
            if (m_irq) rise_seen++;
        end
        vectors++;
        if (rise_seen == 0 || timer_interrupt !== 1'b1) begin
            miscompares++; $display("FAIL irq_asserted: got %b exp 1", timer_interrupt);
        end
        store(5'h08, 3'd2, 32'd100);
        vectors++;
        if (timer_interrupt !== 1'b1) begin
            miscompares++; $display("FAIL irq_hold_on_write_edge: got %b exp 1", timer_interrupt);
        end
        idle(1);
        vectors++;
        if (timer_interrupt !== 1'b0 || m_irq !== 1'b0) begin
            miscompares++; $display("FAIL irq_drop: got %b exp 0", timer_interrupt);
        end
        store(5'h08, 3'd2, 32'd0);
        idle(2);
        vectors++;
        if (timer_interrupt !== 1'b1) begin
            miscompares++; $display("FAIL irq_rearm: got %b exp 1", timer_interrupt);
        end
        // Asynchronous reset must clear the interrupt without a clock edge.
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (timer_interrupt !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_irq: got %b exp 0", timer_interrupt);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        bus(1'b1, 1'b0, BASE, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'd0 || o !== e) begin
            miscompares++; $display("FAIL post_reset_hold: got %h exp 0", o);
        end
    endtask

    task automatic test_carry();
        logic [31:0] o, e; logic oh, eh, oe, ee;
        do_reset();
        store(5'h00, 3'd2, 32'hFFFF_FFFE);
        store(5'h04, 3'd2, 32'd0);
        store(5'h10, 3'd2, 32'd1);
        idle(2);
        bus(1'b1, 1'b0, BASE, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'd0 || o !== e) begin
            miscompares++; $display("FAIL carry_lo: got %h exp 0", o);
        end
        bus(1'b1, 1'b0, BASE + 32'd4, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'd1 || o !== e) begin
            miscompares++; $display("FAIL carry_hi: got %h exp 1", o);
        end
        store(5'h00, 3'd2, 32'h0000_1234);
        bus(1'b1, 1'b0, BASE, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'h0000_1234 || o !== e) begin
            miscompares++; $display("FAIL write_beats_tick: got %h exp 00001234", o);
        end
    endtask

    task automatic test_subword();
        logic [31:0] o, e; logic oh, eh, oe, ee;
        logic [31:0] want[4];
        logic [2:0]  md[4];
        logic [4:0]  off[4];
        do_reset();
        store(5'h09, 3'd0, 32'h0000_0080);
        want = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        md   = '{3'd0, 3'd4, 3'd2, 3'd5};
        off  = '{5'h09, 5'h09, 5'h08, 5'h08};
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b0, BASE | 32'(off[i]), md[i], 32'd0, o, oh, oe, e, eh, ee);
            vectors++;
            if (o !== want[i] || o !== e || oe !== 1'b0) begin
                miscompares++;
                $display("FAIL subword_load %0d: got %h err=%b exp %h err=0", i, o, oe, want[i]);
            end
        end
        store(5'h0E, 3'd1, 32'hABCD_1357);
        bus(1'b1, 1'b0, BASE + 32'h0C, 3'd2, 32'd0, o, oh, oe, e, eh, ee);
        vectors++;
        if (o !== 32'h1357_FFFF || o !== e) begin
            miscompares++; $display("FAIL half_store_lane: got %h exp 1357FFFF", o);
        end
    endtask

    task automatic test_errors();
        logic [31:0] o, e; logic oh, eh, oe, ee;
        logic [31:0] a[6];
        logic [2:0]  md[6];
        logic        we[6];
        logic        wh[6], wer[6];
        do_reset();
        a   = '{BASE + 32'h3, BASE + 32'h2, BASE, BASE + 32'hA, BASE + 32'h18, BASE + 32'h20};
        md  = '{3'd1, 3'd2, 3'd7, 3'd2, 3'd2, 3'd2};
        we  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        wh  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wer = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus(!we[i], we[i], a[i], md[i], 32'h5555_5555, o, oh, oe, e, eh, ee);
            vectors++;
            if (o !== 32'd0 || oh !== wh[i] || oe !== wer[i] || oh !== eh || oe !== ee) begin
                miscompares++;
                $display("FAIL err_case %0d: got rd=%h hit=%b err=%b exp rd=0 hit=%b err=%b", i, o, oh, oe, wh[i], wer[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b0, BASE + 32'(4 * i), 3'd2, 32'd0, o, oh, oe, e, eh, ee);
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL err_no_write off=%0h: got %h exp %h", 4 * i, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] o, e, a, wd; logic oh, eh, oe, ee, rd, wr;
        logic [2:0] md;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 31)));
            md = 3'($urandom_range(0, 7));
            wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
            bus(rd, wr, a, md, wd, o, oh, oe, e, eh, ee);
            vectors++;
            if (o !== e || oh !== eh || oe !== ee || timer_interrupt !== m_irq) begin
                miscompares++;
                $display("FAIL random %0d a=%h md=%0d rd=%b wr=%b: got rd=%h hit=%b err=%b irq=%b exp rd=%h hit=%b err=%b irq=%b",
                         i, a, md, rd, wr, o, oh, oe, timer_interrupt, e, eh, ee, m_irq);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_prescale();
        test_irq();
        test_carry();
        test_subword();
        test_errors();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
